// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants for the PC fetch stage and its neighbours
// (instructionmemory and datamemory share PC_W).
package pc_fetch_unit_pkg;

  localparam int         PC_W         = 10;
  localparam logic [1:0] COMMIT_PHASE = 2'd3;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  typedef enum logic {
    RUN_ACTIVE = 1'b0,
    RUN_HALTED = 1'b1
  } run_mode_e;

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC logic: branch decision, word offset, target and
// misaligned-target detection.
module next_pc_calc #(
  parameter int PC_W = 10
) (
  input  logic [PC_W-1:0] pc,
  input  logic [2:0]      funct3,
  input  logic            branch,
  input  logic            zero,
  input  logic [31:0]     immediate,
  output logic [PC_W-1:0] pc_next,
  output logic            misalign
);
  import pc_fetch_unit_pkg::*;

  logic            take;
  logic [PC_W-1:0] off;
  logic            imm_hi_unused;

  // Unsupported branch funct3 values fall through as not taken.
  assign take = branch & (((funct3 == F3_BEQ) & zero) |
                          ((funct3 == F3_BNE) & ~zero));

  // Byte offset to word offset; the sign is carried by modular addition.
  assign off = immediate[PC_W+1:2];

  assign pc_next  = take ? (pc + off) : (pc + PC_W'(1));
  assign misalign = take & (immediate[1:0] != 2'b00);

  assign imm_hi_unused = ^immediate[31:PC_W+2];

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: holds the PC, commits it once per instruction on the
// commit phase, and tracks halt, misaligned-branch fault and retired count.
module pc_fetch_unit #(
  parameter int              PC_W         = pc_fetch_unit_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter logic [1:0]      COMMIT_PHASE = pc_fetch_unit_pkg::COMMIT_PHASE,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       state,
  input  logic             en,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             branch,
  input  logic             zero,
  input  logic [31:0]      immediate,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_next,
  output logic             commit,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);
  import pc_fetch_unit_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  run_mode_e        run_mode_reg, run_mode_next;
  logic [PC_W-1:0]  pc_reg, pc_reg_next;
  logic             commit_reg, commit_next;
  logic             fault_reg, fault_next;
  logic [CNT_W-1:0] retired_reg, retired_next;

  logic [PC_W-1:0]  target_pc;
  logic             misalign;
  logic             commit_edge;
  logic [CNT_W-1:0] retired_inc;

  next_pc_calc #(
    .PC_W (PC_W)
  ) u_next_pc_calc (
    .pc        (pc_reg),
    .funct3    (funct3),
    .branch    (branch),
    .zero      (zero),
    .immediate (immediate),
    .pc_next   (target_pc),
    .misalign  (misalign)
  );

  assign commit_edge = (state == COMMIT_PHASE) && en && (run_mode_reg == RUN_ACTIVE);
  assign retired_inc = (retired_reg == CNT_MAX) ? retired_reg : retired_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      run_mode_reg <= RUN_ACTIVE;
      pc_reg       <= RESET_PC;
      commit_reg   <= 1'b0;
      fault_reg    <= 1'b0;
      retired_reg  <= '0;
    end else begin
      run_mode_reg <= run_mode_next;
      pc_reg       <= pc_reg_next;
      commit_reg   <= commit_next;
      fault_reg    <= fault_next;
      retired_reg  <= retired_next;
    end
  end

  // SYSTEM wins over a misaligned target; a fault retires nothing.
  always_comb begin
    run_mode_next = run_mode_reg;
    pc_reg_next   = pc_reg;
    commit_next   = 1'b0;
    fault_next    = fault_reg;
    retired_next  = retired_reg;
    if (commit_edge) begin
      if (opcode == OPC_SYSTEM) begin
        run_mode_next = RUN_HALTED;
        retired_next  = retired_inc;
        commit_next   = 1'b1;
      end else if (misalign) begin
        run_mode_next = RUN_HALTED;
        fault_next    = 1'b1;
      end else begin
        pc_reg_next  = target_pc;
        retired_next = retired_inc;
        commit_next  = 1'b1;
      end
    end
  end

  assign pc      = pc_reg;
  assign pc_next = target_pc;
  assign commit  = commit_reg;
  assign halted  = (run_mode_reg == RUN_HALTED);
  assign fault   = fault_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a vector table of whole instructions plus
// hand sequences for fault, halt, mid-instruction reset and counter saturation.
module tb_pc_fetch_unit;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_B   = 7'h63;
  localparam logic [6:0] OP_SYS = 7'h73;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  state = 2'd0;
  logic        en = 1'b1;
  logic [6:0]  opcode = OP_R;
  logic [2:0]  funct3 = 3'd0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] immediate = 32'd0;

  logic [9:0]  pc, pc_next;
  logic        commit, halted, fault;
  logic [15:0] retired;

  // Second instance with a 3-bit counter so saturation is reachable quickly.
  logic [9:0]  s_pc, s_pc_next;
  logic        s_commit, s_halted, s_fault;
  logic [2:0]  s_retired;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .state(state), .en(en), .opcode(opcode),
    .funct3(funct3), .branch(branch), .zero(zero), .immediate(immediate),
    .pc(pc), .pc_next(pc_next), .commit(commit), .halted(halted),
    .fault(fault), .retired(retired)
  );

  pc_fetch_unit #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .state(state), .en(en), .opcode(opcode),
    .funct3(funct3), .branch(branch), .zero(zero), .immediate(immediate),
    .pc(s_pc), .pc_next(s_pc_next), .commit(s_commit), .halted(s_halted),
    .fault(s_fault), .retired(s_retired)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        br;
    logic        z;
    logic [31:0] imm;
    logic        e;
    logic [9:0]  nx;
    logic [9:0]  epc;
    logic [15:0] eret;
    logic        ecm;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [9:0] epc, input logic [15:0] eret,
                             input logic ecm, input logic ehalt, input logic efault);
    logic [15:0] esat;
    esat = (eret > 16'd7) ? 16'd7 : eret;
    chk({tag, " pc"},        32'(pc),        32'(epc));
    chk({tag, " retired"},   32'(retired),   32'(eret));
    chk({tag, " commit"},    32'(commit),    32'(ecm));
    chk({tag, " halted"},    32'(halted),    32'(ehalt));
    chk({tag, " fault"},     32'(fault),     32'(efault));
    chk({tag, " sat pc"},    32'(s_pc),      32'(epc));
    chk({tag, " sat ret"},   32'(s_retired), 32'(esat));
    chk({tag, " sat halt"},  32'(s_halted),  32'(ehalt));
    chk({tag, " sat fault"}, 32'(s_fault),   32'(efault));
    chk({tag, " sat cm"},    32'(s_commit),  32'(ecm));
    $display("[%s] pc=%0d retired=%0d commit=%0b halted=%0b fault=%0b sat_ret=%0d",
             tag, pc, retired, commit, halted, fault, s_retired);
  endtask

  // Runs phases 0..3 of one instruction; starts and ends on a falling edge.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic br,
                           input logic z, input logic [31:0] imm, input logic e,
                           output logic [9:0] nx_seen, output logic cm_mid);
    opcode = op; funct3 = f3; branch = br; zero = z; immediate = imm; en = e;
    state = 2'd0; @(posedge clk); @(negedge clk);
    state = 2'd1; @(posedge clk); @(negedge clk);
    state = 2'd2; cm_mid = commit;
    @(posedge clk); @(negedge clk);
    state = 2'd3; #1 nx_seen = pc_next;
    @(posedge clk); @(negedge clk);
    state = 2'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1; state = 2'd0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic br, input logic z,
                     input logic [31:0] imm, input logic e, input logic [9:0] nx,
                     input logic [9:0] epc, input logic [15:0] eret, input logic ecm);
    vec_t v;
    v.op = op; v.f3 = f3; v.br = br; v.z = z; v.imm = imm; v.e = e;
    v.nx = nx; v.epc = epc; v.eret = eret; v.ecm = ecm;
    vq.push_back(v);
  endtask

  initial begin
    logic [9:0] nx;
    logic       cm_mid;

    for (int i = 0; i < 8; i++)
      add(OP_R, 3'd0, 1'b0, 1'b0, 32'd0, 1'b1, 10'(i + 1), 10'(i + 1), 16'(i + 1), 1'b1);
    add(OP_B, 3'b000, 1'b1, 1'b1, 32'hFFFFFFF4, 1'b1, 10'd5,    10'd5,    16'd9,  1'b1);
    add(OP_B, 3'b000, 1'b1, 1'b1, 32'hFFFFFFF8, 1'b1, 10'd3,    10'd3,    16'd10, 1'b1);
    add(OP_R, 3'b000, 1'b0, 1'b0, 32'd0,        1'b1, 10'd4,    10'd4,    16'd11, 1'b1);
    add(OP_R, 3'b000, 1'b0, 1'b0, 32'd0,        1'b1, 10'd5,    10'd5,    16'd12, 1'b1);
    add(OP_B, 3'b000, 1'b1, 1'b0, 32'hFFFFFFF8, 1'b1, 10'd6,    10'd6,    16'd13, 1'b1);
    add(OP_B, 3'b001, 1'b1, 1'b0, 32'd12,       1'b1, 10'd9,    10'd9,    16'd14, 1'b1);
    add(OP_B, 3'b001, 1'b1, 1'b1, 32'd12,       1'b1, 10'd10,   10'd10,   16'd15, 1'b1);
    add(OP_B, 3'b100, 1'b1, 1'b1, 32'd8,        1'b1, 10'd11,   10'd11,   16'd16, 1'b1);
    add(OP_R, 3'b000, 1'b0, 1'b1, 32'd8,        1'b1, 10'd12,   10'd12,   16'd17, 1'b1);
    add(OP_R, 3'b000, 1'b0, 1'b0, 32'd0,        1'b0, 10'd13,   10'd12,   16'd17, 1'b0);
    add(OP_R, 3'b000, 1'b0, 1'b0, 32'd0,        1'b1, 10'd13,   10'd13,   16'd18, 1'b1);
    add(OP_B, 3'b000, 1'b1, 1'b1, 32'hFFFFFFD0, 1'b1, 10'd1,    10'd1,    16'd19, 1'b1);
    add(OP_B, 3'b000, 1'b1, 1'b1, 32'hFFFFFFF0, 1'b1, 10'd1021, 10'd1021, 16'd20, 1'b1);
    add(OP_B, 3'b001, 1'b1, 1'b1, 32'd6,        1'b1, 10'd1022, 10'd1022, 16'd21, 1'b1);
    add(OP_B, 3'b000, 1'b1, 1'b1, 32'd8,        1'b1, 10'd0,    10'd0,    16'd22, 1'b1);

    @(posedge clk); @(posedge clk); @(negedge clk);
    check_state("reset", 10'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    foreach (vq[i]) begin
      run_instr(vq[i].op, vq[i].f3, vq[i].br, vq[i].z, vq[i].imm, vq[i].e, nx, cm_mid);
      chk($sformatf("v%0d pc_next", i), 32'(nx), 32'(vq[i].nx));
      chk($sformatf("v%0d commit@phase2", i), 32'(cm_mid), 32'd0);
      check_state($sformatf("v%0d", i), vq[i].epc, vq[i].eret, vq[i].ecm, 1'b0, 1'b0);
    end

    // Misaligned taken branch faults and freezes everything until reset.
    run_instr(OP_R, 3'd0, 1'b0, 1'b0, 32'd0, 1'b1, nx, cm_mid);
    check_state("pre-fault", 10'd1, 16'd23, 1'b1, 1'b0, 1'b0);
    run_instr(OP_B, 3'b000, 1'b1, 1'b1, 32'd6, 1'b1, nx, cm_mid);
    check_state("fault", 10'd1, 16'd23, 1'b0, 1'b1, 1'b1);
    run_instr(OP_R, 3'd0, 1'b0, 1'b0, 32'd0, 1'b1, nx, cm_mid);
    check_state("fault hold", 10'd1, 16'd23, 1'b0, 1'b1, 1'b1);
    run_instr(OP_SYS, 3'd0, 1'b0, 1'b0, 32'd0, 1'b1, nx, cm_mid);
    check_state("fault hold sys", 10'd1, 16'd23, 1'b0, 1'b1, 1'b1);
    do_reset();
    check_state("fault reset", 10'd0, 16'd0, 1'b0, 1'b0, 1'b0);

    // SYSTEM at pc=7: retires once, pc stays, then frozen.
    for (int i = 0; i < 7; i++) run_instr(OP_R, 3'd0, 1'b0, 1'b0, 32'd0, 1'b1, nx, cm_mid);
    check_state("pre-sys", 10'd7, 16'd7, 1'b1, 1'b0, 1'b0);
    run_instr(OP_SYS, 3'd0, 1'b0, 1'b0, 32'd0, 1'b1, nx, cm_mid);
    check_state("sys", 10'd7, 16'd8, 1'b1, 1'b1, 1'b0);
    run_instr(OP_R, 3'd0, 1'b0, 1'b0, 32'd0, 1'b1, nx, cm_mid);
    check_state("sys hold", 10'd7, 16'd8, 1'b0, 1'b1, 1'b0);
    do_reset();

    // Reset asserted mid-instruction (phase 1) at pc=9.
    for (int i = 0; i < 9; i++) run_instr(OP_R, 3'd0, 1'b0, 1'b0, 32'd0, 1'b1, nx, cm_mid);
    check_state("pre-rst", 10'd9, 16'd9, 1'b1, 1'b0, 1'b0);
    state = 2'd0; @(posedge clk); @(negedge clk);
    state = 2'd1; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check_state("mid rst", 10'd0, 16'd0, 1'b0, 1'b0, 1'b0);

    // Reset wins over a commit-phase edge.
    state = 2'd3; rst = 1'b1; opcode = OP_R; branch = 1'b0; en = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; state = 2'd0;
    check_state("rst at commit", 10'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    run_instr(OP_R, 3'd0, 1'b0, 1'b0, 32'd0, 1'b1, nx, cm_mid);
    check_state("recover", 10'd1, 16'd1, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
